// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the two-digit BCD scan display: scan states and segment patterns.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    U_ON   = 2'd0,
    GAP_UT = 2'd1,
    T_ON   = 2'd2,
    GAP_TU = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes 10-15 produce a blank pattern.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_disp.sv
// Two-digit multiplexed 7-segment scan driver with blanking gaps and a sticky bad-input flag.
// Define BCD_SCAN_LZ_BLANK_EN to blank a leading zero in the tens digit.
module bcd_scan_disp
  import bcd_disp_pkg::*;
#(
  parameter int DIV = 4,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d,
  input  logic [3:0] u,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int CW = $clog2(max2(DIV, GAP) + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? (GAP - 1) : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    tens_r, units_r;
  logic          err_r;
  logic [3:0]    dig_sel;
  logic [6:0]    dig_seg;
  logic          in_valid;

  assign in_valid = (d <= 4'd9) && (u <= 4'd9);

  // Invalid loads keep the displayed pair and only raise the flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_r  <= 4'd0;
      units_r <= 4'd0;
      err_r   <= 1'b0;
    end else if (load) begin
      if (in_valid) begin
        tens_r  <= d;
        units_r <= u;
        err_r   <= 1'b0;
      end else begin
        err_r   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= U_ON;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // With GAP=0 the gap states are unreachable and ON phases alternate directly
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    case (state)
      U_ON: begin
        if (cnt == ON_LAST) begin
          state_n = (GAP > 0) ? GAP_UT : T_ON;
          cnt_n   = '0;
        end
      end
      GAP_UT: begin
        if (cnt == GAP_LAST) begin
          state_n = T_ON;
          cnt_n   = '0;
        end
      end
      T_ON: begin
        if (cnt == ON_LAST) begin
          state_n = (GAP > 0) ? GAP_TU : U_ON;
          cnt_n   = '0;
        end
      end
      GAP_TU: begin
        if (cnt == GAP_LAST) begin
          state_n = U_ON;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = U_ON;
        cnt_n   = '0;
      end
    endcase
  end

  assign dig_sel = (state == T_ON) ? tens_r : units_r;

  bcd_to_7seg u_dec (
    .bcd (dig_sel),
    .seg (dig_seg)
  );

  always_comb begin
    an  = 2'b00;
    seg = SEG_BLANK;
    case (state)
      U_ON: begin
        an  = 2'b01;
        seg = dig_seg;
      end
      T_ON: begin
`ifdef BCD_SCAN_LZ_BLANK_EN
        if (tens_r != 4'd0) begin
          an  = 2'b10;
          seg = dig_seg;
        end
`else
        an  = 2'b10;
        seg = dig_seg;
`endif
      end
      default: begin
        an  = 2'b00;
        seg = SEG_BLANK;
      end
    endcase
  end

  assign err = err_r;

endmodule
